axilab_slave_regbank: RTL and testbench

- AXI4-Lite slave register bank that sits directly downstream of the axilab_master lab master on its M00_AXI port.
- Absorbs the master's write burst and returns the stored data on the master's read-back pass, so the master's compare/ERROR logic passes end-to-end in hardware.
- Exposes register 0 and a per-write commit pulse to user logic (LEDs, sequencing).

---
 rtl/axilab_slave_regbank.sv | 164 ++++++++++++++++
 tb/tb_axilab_slave_regbank.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilab_slave_regbank.sv
// AXI4-Lite slave register bank.
// Absorbs writes into NUM_REGS 32-bit registers and serves reads back.
// Exposes register 0 and a per-write commit pulse to user logic.
// Ports:
//   ACLK, ARESETN     clock and async active-low reset
//   S_AXI_AW*/W*/B*   write address, data and response channels
//   S_AXI_AR*/R*      read address and data channels
//   REG0_OUT          live copy of register 0
//   WR_PULSE          one-cycle pulse per committed in-range write
//   WR_INDEX          index of the last committed in-range write
module axilab_slave_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          REG0_OUT,
  output logic                                   WR_PULSE,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] WR_INDEX
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned WI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic             aw_full;
  logic [IDX_W-1:0] aw_idx;
  logic             w_full;
  logic [DW-1:0]    w_data;
  logic [SW-1:0]    w_strb;
  logic [DW-1:0]    regs [NUM_REGS];

  logic             aw_hs_c;
  logic             w_hs_c;
  logic             ar_hs_c;
  logic             commit_c;
  logic             aw_in_range_c;
  logic [IDX_W-1:0] ar_idx_c;
  logic             ar_in_range_c;
  logic [DW-1:0]    rd_val_c;
  logic             unused_c;

  assign aw_hs_c       = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs_c        = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs_c       = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit_c      = aw_full & w_full & ~S_AXI_BVALID;
  assign aw_in_range_c = 32'(aw_idx) < NUM_REGS;
  assign ar_idx_c      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_in_range_c = 32'(ar_idx_c) < NUM_REGS;
  assign REG0_OUT      = regs[0];

  // Byte-lane offsets and protection bits carry no meaning here.
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Read mux; out-of-range indices match no register and yield zero.
  always_comb begin
    rd_val_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_c == IDX_W'(i)) rd_val_c = regs[i];
    end
  end

  // AW/W one-entry buffers, B channel and commit side-band.
  // READY mirrors the buffer's next-cycle emptiness so it is a plain flop.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full       <= 1'b0;
      aw_idx        <= '0;
      w_full        <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      WR_PULSE      <= 1'b0;
      WR_INDEX      <= '0;
    end else begin
      if (commit_c) begin
        aw_full <= 1'b0;
      end else if (aw_hs_c) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (commit_c) begin
        w_full <= 1'b0;
      end else if (w_hs_c) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      S_AXI_AWREADY <= commit_c | ~(aw_full | aw_hs_c);
      S_AXI_WREADY  <= commit_c | ~(w_full | w_hs_c);

      // Commit is blocked while BVALID is high, so set and clear never collide.
      if (commit_c) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      WR_PULSE <= commit_c & aw_in_range_c;
      if (commit_c & aw_in_range_c) WR_INDEX <= WI_W'(aw_idx);
    end
  end

  // Register file with byte-enable writes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_c & aw_in_range_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < SW; b++) begin
          if ((aw_idx == IDX_W'(i)) && w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel; captures pre-write contents when colliding with a commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else if (ar_hs_c) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b1;
      S_AXI_RDATA   <= rd_val_c;
      S_AXI_RRESP   <= ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID & S_AXI_RREADY) begin
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
    end else if (!S_AXI_RVALID) begin
      S_AXI_ARREADY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axilab_slave_regbank.sv
// Self-checking bench for axilab_slave_regbank: a register model feeds
// expected B and R responses into queues that are popped on DUT responses.
module tb_axilab_slave_regbank;

  localparam int unsigned AW_W = 6;
  localparam int unsigned NR   = 8;
  localparam int unsigned IW   = 3;

  typedef struct packed {
    logic [1:0]    resp;
    logic          pulse;
    logic [IW-1:0] idx;
  } bexp_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic            clk;
  logic            rst_n;
  logic [AW_W-1:0] awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW_W-1:0] araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  logic [31:0]     reg0_out;
  logic            wr_pulse;
  logic [IW-1:0]   wr_index;

  int checks = 0;
  int errors = 0;

  logic [31:0]   model [NR];
  logic [IW-1:0] last_idx;
  bexp_t         exp_b_q [$];
  rexp_t         exp_r_q [$];

  axilab_slave_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW_W),
    .NUM_REGS(NR)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG0_OUT(reg0_out), .WR_PULSE(wr_pulse), .WR_INDEX(wr_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
    last_idx = '0;
    exp_b_q.delete();
    exp_r_q.delete();
  endtask

  task automatic model_write(input logic [AW_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    bexp_t e;
    idx = int'(a[AW_W-1:2]);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      last_idx = IW'(idx);
      e = '{resp: 2'b00, pulse: 1'b1, idx: last_idx};
    end else begin
      e = '{resp: 2'b10, pulse: 1'b0, idx: last_idx};
    end
    exp_b_q.push_back(e);
  endtask

  task automatic model_read(input logic [AW_W-1:0] a);
    int idx;
    idx = int'(a[AW_W-1:2]);
    if (idx < NR) exp_r_q.push_back('{resp: 2'b00, data: model[idx]});
    else          exp_r_q.push_back('{resp: 2'b10, data: 32'h0});
  endtask

  task automatic issue_write(input logic [AW_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output bit ok);
    bit a_done;
    bit w_done;
    a_done = 1'b0;
    w_done = 1'b0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 40 && !(a_done && w_done); k++) begin
      bit ah;
      bit wh;
      ah = awvalid && awready;
      wh = wvalid && wready;
      cyc();
      if (ah) begin a_done = 1'b1; awvalid = 1'b0; end
      if (wh) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    ok = a_done && w_done;
  endtask

  task automatic issue_aw(input logic [AW_W-1:0] a, output bit ok);
    ok = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = awready;
      cyc();
    end
    awvalid = 1'b0;
  endtask

  task automatic issue_w(input logic [31:0] d, input logic [3:0] s, output bit ok);
    ok = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = wready;
      cyc();
    end
    wvalid = 1'b0;
  endtask

  task automatic issue_ar(input logic [AW_W-1:0] a, output bit ok);
    ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = arready;
      cyc();
    end
    arvalid = 1'b0;
  endtask

  // Waits for BVALID; captures side-band seen in that same cycle.
  task automatic wait_b(input int budget, output bit got, output int waited,
                        output bexp_t obs, output logic [31:0] r0);
    got = 1'b0; waited = 0; obs = '0; r0 = '0;
    for (int k = 0; k < budget; k++) begin
      if (bvalid) begin
        got = 1'b1;
        obs = '{resp: bresp, pulse: wr_pulse, idx: wr_index};
        r0  = reg0_out;
        if (bready) cyc();
        return;
      end
      cyc();
      waited++;
    end
  endtask

  task automatic wait_r(input int budget, output bit got, output int waited, output rexp_t obs);
    got = 1'b0; waited = 0; obs = '0;
    for (int k = 0; k < budget; k++) begin
      if (rvalid) begin
        got = 1'b1;
        obs = '{resp: rresp, data: rdata};
        if (rready) cyc();
        return;
      end
      cyc();
      waited++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    repeat (3) cyc();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, wr_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {awready, wready, arready, bvalid, rvalid, wr_pulse});
    end
    checks++;
    if ({bresp, rresp, rdata, wr_index, reg0_out} !== '0) begin
      errors++;
      $display("FAIL reset_data: bresp %b rresp %b rdata %h idx %0d reg0 %h expected all zero",
               bresp, rresp, rdata, wr_index, reg0_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic_write_read();
    bit ok, got;
    int waited;
    bexp_t ob, eb;
    rexp_t orr, er;
    logic [31:0] r0;
    bready = 1'b1; rready = 1'b1;
    model_write(6'h04, 32'hA5A5_1234, 4'hF);
    issue_write(6'h04, 32'hA5A5_1234, 4'hF, ok);
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({ok, got, ob} !== {2'b11, eb}) begin
      errors++;
      $display("FAIL basic_bresp: ok %0b got %0b obs %h expected %h", ok, got, ob, eb);
    end
    checks++;
    if (waited !== 1) begin
      errors++;
      $display("FAIL basic_b_latency: waited %0d expected 1", waited);
    end
    model_read(6'h04);
    issue_ar(6'h04, ok);
    checks++;
    if ({ok, rvalid, arready} !== 3'b110) begin
      errors++;
      $display("FAIL basic_ar_state: ok/rvalid/arready %b expected 110", {ok, rvalid, arready});
    end
    wait_r(10, got, waited, orr);
    er = exp_r_q.pop_front();
    checks++;
    if ({got, orr} !== {1'b1, er}) begin
      errors++;
      $display("FAIL basic_read: got %0b obs %h expected %h", got, orr, er);
    end
  endtask

  task automatic test_w_before_aw();
    bit ok, got;
    int waited;
    bexp_t ob, eb;
    logic [31:0] r0;
    bready = 1'b1;
    issue_w(32'h0000_00FF, 4'h1, ok);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ok, wready} !== 2'b10) begin
        errors++;
        $display("FAIL wfirst_wready: ok/wready %b expected 10 at cycle %0d", {ok, wready}, k);
      end
      cyc();
    end
    model_write(6'h00, 32'h0000_00FF, 4'h1);
    issue_aw(6'h00, ok);
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({ok, got, ob, r0} !== {2'b11, eb, model[0]}) begin
      errors++;
      $display("FAIL wfirst_commit: obs %h reg0 %h expected %h reg0 %h", ob, r0, eb, model[0]);
    end
    model_write(6'h00, 32'hFFFF_FF00, 4'hC);
    issue_write(6'h00, 32'hFFFF_FF00, 4'hC, ok);
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({ok, got, ob, r0} !== {2'b11, eb, 32'hFFFF_00FF}) begin
      errors++;
      $display("FAIL wstrb_merge: obs %h reg0 %h expected %h reg0 ffff00ff", ob, r0, eb);
    end
  endtask

  task automatic test_out_of_range();
    bit ok, got;
    int waited;
    bexp_t ob, eb;
    rexp_t orr, er;
    logic [31:0] r0;
    bready = 1'b1; rready = 1'b1;
    model_write(6'h3C, 32'hDEAD_BEEF, 4'hF);
    issue_write(6'h3C, 32'hDEAD_BEEF, 4'hF, ok);
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({ok, got, ob, r0} !== {2'b11, eb, model[0]}) begin
      errors++;
      $display("FAIL oor_write: obs %h reg0 %h expected %h reg0 %h", ob, r0, eb, model[0]);
    end
    for (int i = 0; i < 2; i++) begin
      logic [AW_W-1:0] a;
      a = (i == 0) ? 6'h3C : 6'h04;
      model_read(a);
      issue_ar(a, ok);
      wait_r(10, got, waited, orr);
      er = exp_r_q.pop_front();
      checks++;
      if ({ok, got, orr} !== {2'b11, er}) begin
        errors++;
        $display("FAIL oor_read_%0h: obs %h expected %h", a, orr, er);
      end
    end
  endtask

  task automatic test_b_backpressure();
    bit ok, got;
    int waited;
    bexp_t ob, eb;
    logic [31:0] r0;
    bready = 1'b0;
    model_write(6'h08, 32'h1111_2222, 4'hF);
    issue_write(6'h08, 32'h1111_2222, 4'hF, ok);
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({ok, got, ob} !== {2'b11, eb}) begin
      errors++;
      $display("FAIL bp_first: obs %h expected %h", ob, eb);
    end
    model_write(6'h0C, 32'h3333_4444, 4'hF);
    issue_write(6'h0C, 32'h3333_4444, 4'hF, ok);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({ok, bvalid, bresp, wr_pulse} !== 5'b11000) begin
        errors++;
        $display("FAIL bp_hold: ok/bvalid/bresp/pulse %b expected 11000 at cycle %0d",
                 {ok, bvalid, bresp, wr_pulse}, k);
      end
      cyc();
    end
    bready = 1'b1;
    cyc();
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: bvalid %b expected 0", bvalid);
    end
    wait_b(10, got, waited, ob, r0);
    eb = exp_b_q.pop_front();
    checks++;
    if ({got, ob, 32'(waited)} !== {1'b1, eb, 32'd1}) begin
      errors++;
      $display("FAIL bp_second: obs %h waited %0d expected %h waited 1", ob, waited, eb);
    end
  endtask

  task automatic test_r_backpressure();
    bit ok, got;
    int waited;
    rexp_t orr, er;
    rready = 1'b0;
    model_read(6'h08);
    issue_ar(6'h08, ok);
    er = exp_r_q[0];
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({ok, rvalid, arready, rresp, rdata} !== {3'b110, er}) begin
        errors++;
        $display("FAIL rbp_hold: rvalid %b arready %b resp %b data %h expected %h at cycle %0d",
                 rvalid, arready, rresp, rdata, er, k);
      end
      cyc();
    end
    rready = 1'b1;
    wait_r(10, got, waited, orr);
    er = exp_r_q.pop_front();
    checks++;
    if ({got, orr} !== {1'b1, er}) begin
      errors++;
      $display("FAIL rbp_data: obs %h expected %h", orr, er);
    end
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL rbp_release: rvalid/arready %b expected 01", {rvalid, arready});
    end
  endtask

  task automatic test_master_sequence();
    bit ok, got;
    int waited;
    bexp_t ob, eb;
    rexp_t orr, er;
    logic [31:0] r0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_write(AW_W'(4 * i), 32'hC0DE_0001 + 32'(i), 4'hF);
      issue_write(AW_W'(4 * i), 32'hC0DE_0001 + 32'(i), 4'hF, ok);
      wait_b(10, got, waited, ob, r0);
      eb = exp_b_q.pop_front();
      checks++;
      if ({ok, got, ob} !== {2'b11, eb}) begin
        errors++;
        $display("FAIL seq_write_%0d: obs %h expected %h", i, ob, eb);
      end
    end
    for (int i = 0; i < 4; i++) begin
      model_read(AW_W'(4 * i));
      issue_ar(AW_W'(4 * i), ok);
      wait_r(10, got, waited, orr);
      er = exp_r_q.pop_front();
      checks++;
      if ({ok, got, orr} !== {2'b11, er}) begin
        errors++;
        $display("FAIL seq_read_%0d: obs %h expected %h", i, orr, er);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    int waited;
    bexp_t ob;
    rexp_t orr, er;
    logic [31:0] r0;
    bready = 1'b1; rready = 1'b1;
    issue_aw(6'h00, ok);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp, rdata, wr_index, reg0_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: ready %b valid %b pulse %b reg0 %h rdata %h expected all zero",
               {awready, wready, arready}, {bvalid, rvalid}, wr_pulse, reg0_out, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    issue_w(32'h1234_5678, 4'hF, ok);
    wait_b(8, got, waited, ob, r0);
    checks++;
    if ({ok, got} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_no_b: ok %0b bvalid_seen %0b expected 1 0", ok, got);
    end
    model_read(6'h00);
    issue_ar(6'h00, ok);
    wait_r(10, got, waited, orr);
    er = exp_r_q.pop_front();
    checks++;
    if ({ok, got, orr} !== {2'b11, er}) begin
      errors++;
      $display("FAIL midreset_reg0: obs %h expected %h", orr, er);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_out_of_range();
    test_b_backpressure();
    test_r_backpressure();
    test_master_sequence();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
